// File: rtl/jtkicker_pkg.sv
// Shared definitions for the jtkicker graphics ROM arbiter:
// FSM state encoding, client indices and the transaction timeout limit.
package jtkicker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_DST = 2'd2
  } gfx_state_t;

  localparam logic CLI_SCR = 1'b0;
  localparam logic CLI_OBJ = 1'b1;

  // Cycle count in REQ/WAIT_DST after which an unanswered transaction is dropped
  localparam int unsigned TMO_MAX = 63;

endpackage

// File: rtl/jtkicker_gfx_slot.sv
// Per-client cache slot: remembers the last served address, a valid bit and
// the last delivered word, and derives the client's ok / pending status.
module jtkicker_gfx_slot #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          wr,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   data,
  output logic          ok,
  output logic          pending
);

  logic [AW-1:0] served_q;
  logic          valid_q;
  logic [31:0]   data_q;
  logic          match;

  // Capture a completed delivery: word, the address it was fetched for, valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      served_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else if (wr) begin
      served_q <= wr_addr;
      valid_q  <= 1'b1;
      data_q   <= wr_data;
    end
  end

  assign match   = (addr == served_q);
  assign ok      = cs & valid_q & match;
  assign pending = cs & (~valid_q | ~match);
  assign data    = data_q;

endmodule

// File: rtl/jtkicker_gfx_arb.sv
// Two-client SDRAM arbiter for the scroll and object graphics ROMs.
// Scroll has fixed priority; the object client is forced through after
// STARVE consecutive scroll grants made while it was waiting.
// Optional feature: define JTKICKER_GFX_TIMEOUT_EN to abort transactions
// that stay unanswered for 63 cycles and raise the sticky err flag.
module jtkicker_gfx_arb
  import jtkicker_pkg::*;
#(
  parameter int                  SDRAM_AW   = 22,
  parameter int                  SCR_AW     = 13,
  parameter int                  OBJ_AW     = 14,
  parameter logic [SDRAM_AW-1:0] SCR_OFFSET = 22'h0,
  parameter logic [SDRAM_AW-1:0] OBJ_OFFSET = 22'h2000,
  parameter int                  STARVE     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scr_cs,
  input  logic [SCR_AW-1:0]   scr_addr,
  output logic [31:0]         scr_data,
  output logic                scr_ok,
  input  logic                obj_cs,
  input  logic [OBJ_AW-1:0]   obj_addr,
  output logic [31:0]         obj_data,
  output logic                obj_ok,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                sdram_dst,
  input  logic [31:0]         sdram_data,
  output logic                err
);

  localparam int              SW       = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
  localparam logic [SW-1:0]   STARVE_W = SW'(STARVE);

  gfx_state_t          st_q, st_d;
  logic                req_q, req_d;
  logic [SDRAM_AW-1:0] addr_q, addr_d;
  logic                cli_q, cli_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [SCR_AW-1:0]   scr_lat_q, scr_lat_d;
  logic [OBJ_AW-1:0]   obj_lat_q, obj_lat_d;
  logic                store;
  logic                scr_pend, obj_pend, obj_win;
`ifdef JTKICKER_GFX_TIMEOUT_EN
  logic [5:0]          tmo_q, tmo_d;
  logic                err_q, err_d;
`endif

  jtkicker_gfx_slot #(.AW(SCR_AW)) u_scr (
    .clk(clk), .rst(rst), .cs(scr_cs), .addr(scr_addr),
    .wr(store && (cli_q == CLI_SCR)), .wr_addr(scr_lat_q), .wr_data(sdram_data),
    .data(scr_data), .ok(scr_ok), .pending(scr_pend)
  );

  jtkicker_gfx_slot #(.AW(OBJ_AW)) u_obj (
    .clk(clk), .rst(rst), .cs(obj_cs), .addr(obj_addr),
    .wr(store && (cli_q == CLI_OBJ)), .wr_addr(obj_lat_q), .wr_data(sdram_data),
    .data(obj_data), .ok(obj_ok), .pending(obj_pend)
  );

  assign obj_win = obj_pend & (~scr_pend | (starve_q == STARVE_W));

  // Next-state: arbitration in IDLE, request handshake, data capture, timeout
  always_comb begin
    st_d      = st_q;
    req_d     = req_q;
    addr_d    = addr_q;
    cli_d     = cli_q;
    starve_d  = starve_q;
    scr_lat_d = scr_lat_q;
    obj_lat_d = obj_lat_q;
    store     = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (scr_pend || obj_pend) begin
          st_d  = ST_REQ;
          req_d = 1'b1;
          if (obj_win) begin
            cli_d     = CLI_OBJ;
            obj_lat_d = obj_addr;
            addr_d    = OBJ_OFFSET + SDRAM_AW'(obj_addr);
            starve_d  = '0;
          end else begin
            cli_d     = CLI_SCR;
            scr_lat_d = scr_addr;
            addr_d    = SCR_OFFSET + SDRAM_AW'(scr_addr);
            if (obj_pend && (starve_q != STARVE_W)) starve_d = starve_q + SW'(1);
          end
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          req_d = 1'b0;
          if (sdram_dst) begin
            store = 1'b1;
            st_d  = ST_IDLE;
          end else begin
            st_d  = ST_WAIT_DST;
          end
        end
      end
      ST_WAIT_DST: begin
        if (sdram_dst) begin
          store = 1'b1;
          st_d  = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
`ifdef JTKICKER_GFX_TIMEOUT_EN
    // A delivery in the expiry cycle still completes normally
    tmo_d = '0;
    err_d = err_q;
    if (st_q != ST_IDLE) begin
      tmo_d = tmo_q + 6'd1;
      if (!store && (tmo_q == 6'(TMO_MAX))) begin
        st_d  = ST_IDLE;
        req_d = 1'b0;
        tmo_d = '0;
        err_d = 1'b1;
      end
    end
`endif
  end

  // State and transaction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      req_q     <= 1'b0;
      addr_q    <= '0;
      cli_q     <= CLI_SCR;
      starve_q  <= '0;
      scr_lat_q <= '0;
      obj_lat_q <= '0;
    end else begin
      st_q      <= st_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      cli_q     <= cli_d;
      starve_q  <= starve_d;
      scr_lat_q <= scr_lat_d;
      obj_lat_q <= obj_lat_d;
    end
  end

`ifdef JTKICKER_GFX_TIMEOUT_EN
  // Timeout counter and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

endmodule
